// File: rtl/act_store_writer.sv
`default_nettype none
//==============================================================================
// Module   : act_store_writer
// Purpose  : Captures one NUM-word layer result and writes it word by word
//            into the activation RAM at a base address chosen by the layer.
// Option   : WRITER_STALL_EN adds a stall input that pauses the burst.
// Revision : 1.0 - initial release
//==============================================================================

`ifndef DATA_LEN
`define DATA_LEN 16
`endif
`ifndef LAYER0
`define LAYER0 4'd0
`endif
`ifndef LAYER1
`define LAYER1 4'd1
`endif
`ifndef LAYER2
`define LAYER2 4'd2
`endif
`ifndef LAYER3
`define LAYER3 4'd3
`endif
`ifndef AFFINE
`define AFFINE 4'd4
`endif

module act_store_writer #(
  parameter int NUM    = 288,
  parameter int ADDR_W = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              cs,
  input  logic                    d_valid,
  input  logic [NUM*`DATA_LEN-1:0] d,
`ifdef WRITER_STALL_EN
  input  logic                    stall,
`endif
  output logic                    ready,
  output logic                    we,
  output logic [ADDR_W-1:0]       addr,
  output logic [`DATA_LEN-1:0]    wdata,
  output logic                    done
);

  localparam int DW    = `DATA_LEN;
  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM - 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_HOLD  = 3'd1,
    S_IDLE  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cs_prev;
  logic [ADDR_W-1:0]   r_base, w_base_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [NUM*DW-1:0]   r_buf;
  logic                w_buf_load;
  logic                w_ready_nxt, w_we_nxt, w_done_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DW-1:0]       w_wdata_nxt;
  logic [ADDR_W-1:0]   w_cs_base;
  logic                w_cs_valid;
  logic                w_stall;

`ifdef WRITER_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_cs_valid = 1'b1;
    w_cs_base  = '0;
    case (cs)
      `LAYER0: w_cs_base = '0;
      `LAYER1: w_cs_base = ADDR_W'(NUM);
      `LAYER2: w_cs_base = ADDR_W'(2 * NUM);
      `LAYER3: w_cs_base = ADDR_W'(3 * NUM);
      `AFFINE: w_cs_base = ADDR_W'(4 * NUM);
      default: w_cs_valid = 1'b0;
    endcase
  end

  // Outputs are registered, so every branch computes the value seen next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_idx_nxt   = r_idx;
    w_buf_load  = 1'b0;
    w_ready_nxt = 1'b0;
    w_we_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_addr_nxt  = addr;
    w_wdata_nxt = wdata;
    if (cs != r_cs_prev) begin
      w_state_nxt = S_INIT;
    end else begin
      case (r_state)
        S_INIT: begin
          w_base_nxt = w_cs_base;
          w_idx_nxt  = '0;
          if (w_cs_valid) begin
            w_state_nxt = S_IDLE;
            w_ready_nxt = 1'b1;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          w_state_nxt = S_HOLD;
        end
        S_IDLE: begin
          // Word 0 comes straight from d since the buffer loads on this same edge.
          if (d_valid && ready) begin
            w_buf_load  = 1'b1;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = r_base;
            w_wdata_nxt = d[DW-1:0];
            w_idx_nxt   = IDX_W'(1);
            w_state_nxt = (NUM == 1) ? S_DONE : S_WRITE;
          end else begin
            w_ready_nxt = 1'b1;
          end
        end
        S_WRITE: begin
          w_addr_nxt  = r_base + ADDR_W'(r_idx);
          w_wdata_nxt = r_buf[r_idx*DW +: DW];
          if (!w_stall) begin
            w_we_nxt  = 1'b1;
            w_idx_nxt = r_idx + IDX_W'(1);
            if (r_idx == c_IDX_LAST) begin
              w_state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_INIT;
      r_cs_prev <= 4'hF;
      r_base    <= '0;
      r_idx     <= '0;
      ready     <= 1'b0;
      we        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cs_prev <= cs;
      r_base    <= w_base_nxt;
      r_idx     <= w_idx_nxt;
      ready     <= w_ready_nxt;
      we        <= w_we_nxt;
      addr      <= w_addr_nxt;
      wdata     <= w_wdata_nxt;
      done      <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_load) begin
      r_buf <= d;
    end
  end

endmodule

`default_nettype wire
